tagged_memory_ctl: RTL and testbench

Parametrised tagged-memory bus target: word memory with per-word tags behind the CPU's multiplexed address/data bus (address strobe, atomic, read, write). It adds configurable wait states, an explicit ready/ack handshake, address auto-increment for streaming access, and a read-modify-write lock indicator. It sits between the CPU bus outputs and the CPU's data/tag inputs, and is synthesizable.

---
 rtl/tagged_memory_ctl.sv | 152 +++++++++++++++
 tb/tb_tagged_memory_ctl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tagged_memory_ctl.sv
// Tagged word memory behind a multiplexed address/data CPU bus, with programmable
// wait states, ack/ready handshake, optional address auto-increment and an RMW lock flag.
module tagged_memory_ctl #(
    parameter int AW   = 20,
    parameter int DW   = 64,
    parameter int TW   = 8,
    parameter int WAIT = 0,
    parameter int INC  = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] i_ad,
    input  logic [TW-1:0] i_tag,
    input  logic          i_astb,
    input  logic          i_atomic,
    input  logic          i_rd,
    input  logic          i_wr,
    output logic [DW-1:0] o_data,
    output logic [TW-1:0] o_tag,
    output logic          o_ack,
    output logic          o_ready,
    output logic          o_locked,
    output logic          o_err
);

    localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          locked_q, locked_d;
    logic          op_wr_q;
    logic [DW-1:0] wdata_q;
    logic [TW-1:0] wtag_q;
    logic [DW-1:0] data_q;
    logic [TW-1:0] tag_q;
    logic          ack_q;
    logic          err_q;

    logic [DW-1:0] mem_data [2**AW];
    logic [TW-1:0] mem_tag  [2**AW];

    logic          busy, req, illegal;
    logic          acc_astb, acc_rd, acc_wr;
    logic          cmp_rd, cmp_wr, cmp_lock;
    logic [AW-1:0] cmp_addr, addr_inc;
    logic [DW-1:0] cmp_wdata;
    logic [TW-1:0] cmp_wtag;

    always_comb begin
        busy     = (state_q == ST_WAIT);
        req      = i_astb | i_rd | i_wr;
        illegal  = req & (busy | (i_astb & i_wr) | (i_rd & i_wr));
        acc_astb = ~busy & i_astb & ~i_wr;
        acc_rd   = ~busy & i_rd & ~i_wr;
        acc_wr   = ~busy & i_wr & ~i_astb & ~i_rd;

        // Without wait states an operation completes on its own acceptance edge,
        // so a strobe in the same cycle must steer the address and lock directly.
        if (WAIT == 0) begin
            cmp_rd    = acc_rd;
            cmp_wr    = acc_wr;
            cmp_addr  = acc_astb ? i_ad[AW-1:0] : waddr_q;
            cmp_lock  = acc_astb ? i_atomic : locked_q;
            cmp_wdata = i_ad;
            cmp_wtag  = i_tag;
        end else begin
            cmp_rd    = busy & (cnt_q == CW'(1)) & ~op_wr_q;
            cmp_wr    = busy & (cnt_q == CW'(1)) & op_wr_q;
            cmp_addr  = waddr_q;
            cmp_lock  = locked_q;
            cmp_wdata = wdata_q;
            cmp_wtag  = wtag_q;
        end

        addr_inc = cmp_addr + AW'(1);
        waddr_d  = waddr_q;
        locked_d = locked_q;
        if (acc_astb) begin
            waddr_d  = i_ad[AW-1:0];
            locked_d = i_atomic;
        end
        if (cmp_wr) begin
            locked_d = 1'b0;
            if (INC != 0) waddr_d = addr_inc;
        end
        // A locked read holds the address so the following write hits the same word.
        if (cmp_rd && !cmp_lock && (INC != 0)) waddr_d = addr_inc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            waddr_q  <= '0;
            locked_q <= 1'b0;
            op_wr_q  <= 1'b0;
            wdata_q  <= '0;
            wtag_q   <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            waddr_q  <= waddr_d;
            locked_q <= locked_d;
            err_q    <= illegal;
            ack_q    <= cmp_rd | cmp_wr;
            if (cmp_rd) begin
                data_q <= mem_data[cmp_addr];
                tag_q  <= mem_tag[cmp_addr];
            end
            if (acc_rd | acc_wr) begin
                op_wr_q <= acc_wr;
                wdata_q <= i_ad;
                wtag_q  <= i_tag;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (acc_rd | acc_wr) begin
                        state_q <= (WAIT == 0) ? ST_DONE : ST_WAIT;
                        cnt_q   <= CW'(WAIT);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cmp_wr) begin
            mem_data[cmp_addr] <= cmp_wdata;
            mem_tag[cmp_addr]  <= cmp_wtag;
        end
    end

    assign o_data   = data_q;
    assign o_tag    = tag_q;
    assign o_ack    = ack_q;
    assign o_ready  = ~busy;
    assign o_locked = locked_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_tagged_memory_ctl.sv
// Bench for tagged_memory_ctl: three instances (WAIT/INC = 0/0, 3/1, 5/0) driven one at a
// time from a shared bus, checked against a transaction-level memory/address model.
module tb_tagged_memory_ctl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] ad;
    logic [7:0]  tg;
    logic        astb, atomic, rd, wr;
    int          sel;

    logic [63:0] data_w [3];
    logic [7:0]  tag_w  [3];
    logic        ack_w  [3];
    logic        rdy_w  [3];
    logic        lck_w  [3];
    logic        err_w  [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        logic s;
        assign s = (sel == k);
        tagged_memory_ctl #(
            .AW(20), .DW(64), .TW(8),
            .WAIT((k == 0) ? 0 : (k == 1) ? 3 : 5),
            .INC((k == 1) ? 1 : 0)
        ) u_dut (
            .clk(clk), .reset_n(reset_n),
            .i_ad(ad), .i_tag(tg),
            .i_astb(astb & s), .i_atomic(atomic), .i_rd(rd & s), .i_wr(wr & s),
            .o_data(data_w[k]), .o_tag(tag_w[k]), .o_ack(ack_w[k]),
            .o_ready(rdy_w[k]), .o_locked(lck_w[k]), .o_err(err_w[k])
        );
    end

    // Reference model: what each instance's address pointer, lock and memory should be.
    int          waitv [3] = '{0, 3, 5};
    bit          incv  [3] = '{1'b0, 1'b1, 1'b0};
    logic [19:0] m_addr [3];
    bit          m_lock [3];
    logic [71:0] m_last [3];
    bit          m_last_ok [3];
    logic [71:0] m_mem [int];

    int total = 0;
    int fails = 0;

    function automatic int key_of(input int s, input logic [19:0] a);
        return s * (1 << 20) + int'(a);
    endfunction

    task automatic chk(input string nm, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (dut %0d): observed %h expected %h", nm, sel, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        astb = 1'b0; rd = 1'b0; wr = 1'b0; atomic = 1'b0;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_addr[s] = '0; m_lock[s] = 1'b0; m_last[s] = '0; m_last_ok[s] = 1'b1;
        end
    endtask

    task automatic astb_op(input logic [19:0] a, input bit at);
        ad = {44'h0, a}; atomic = at; astb = 1'b1;
        step(); clr();
        m_addr[sel] = a; m_lock[sel] = at;
        chk("astb_no_ack", ack_w[sel], 0);
        chk("astb_lock", lck_w[sel], at);
        chk("astb_no_err", err_w[sel], 0);
    endtask

    task automatic xfer(input bit is_wr, input bit with_astb, input logic [19:0] a,
                        input bit at, input logic [63:0] d, input logic [7:0] t);
        int key;
        if (with_astb) begin
            ad = {44'h0, a}; atomic = at; astb = 1'b1;
            m_addr[sel] = a; m_lock[sel] = at;
        end
        if (is_wr) begin ad = d; tg = t; wr = 1'b1; end
        else rd = 1'b1;
        step(); clr();
        for (int i = 0; i < waitv[sel]; i++) begin
            chk("busy_ready_low", rdy_w[sel], 0);
            chk("busy_no_ack", ack_w[sel], 0);
            step();
        end
        chk("ack", ack_w[sel], 1);
        chk("ready_at_ack", rdy_w[sel], 1);
        chk("no_err", err_w[sel], 0);
        key = key_of(sel, m_addr[sel]);
        if (is_wr) begin
            m_mem[key] = {d, t};
            if (m_last_ok[sel]) chk("rd_data_hold", {data_w[sel], tag_w[sel]}, m_last[sel]);
            m_lock[sel] = 1'b0;
            if (incv[sel]) m_addr[sel] = m_addr[sel] + 20'd1;
        end else begin
            if (m_mem.exists(key)) begin
                chk("rd_data", {data_w[sel], tag_w[sel]}, m_mem[key]);
                m_last[sel] = m_mem[key]; m_last_ok[sel] = 1'b1;
            end else begin
                m_last_ok[sel] = 1'b0;
            end
            if (!m_lock[sel] && incv[sel]) m_addr[sel] = m_addr[sel] + 20'd1;
        end
        chk("lock_after", lck_w[sel], m_lock[sel]);
    endtask

    task automatic wr_op(input logic [63:0] d, input logic [7:0] t);
        xfer(1'b1, 1'b0, '0, 1'b0, d, t);
    endtask

    task automatic rd_op();
        xfer(1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic bad(input bit a_s, input bit r, input bit w);
        ad = {$urandom, $urandom}; tg = 8'($urandom); atomic = 1'($urandom);
        astb = a_s; rd = r; wr = w;
        step(); clr();
        chk("err_pulse", err_w[sel], 1);
        chk("err_no_ack", ack_w[sel], 0);
        step();
        chk("err_one_cycle", err_w[sel], 0);
        chk("err_lock_kept", lck_w[sel], m_lock[sel]);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] a;
        int          r;
        reset_n = 1'b0; sel = 0; ad = '0; tg = '0; clr();
        model_reset();
        step(); step();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            chk("rst_data", {data_w[s], tag_w[s]}, 0);
            chk("rst_ack", ack_w[s], 0);
            chk("rst_err", err_w[s], 0);
            chk("rst_lock", lck_w[s], 0);
            chk("rst_ready", rdy_w[s], 1);
        end
        reset_n = 1'b1;
        step();

        // Basic write then read, WAIT=0/INC=0, including read-after-write in the ack cycle.
        sel = 0;
        astb_op(20'h00010, 1'b0);
        wr_op(64'h0123456789ABCDEF, 8'h34);
        rd_op();
        chk("t1_rd", {data_w[0], tag_w[0]}, {64'h0123456789ABCDEF, 8'h34});
        wr_op(64'hDEADBEEF00C0FFEE, 8'h5A);
        rd_op();
        chk("t1_raw", {data_w[0], tag_w[0]}, {64'hDEADBEEF00C0FFEE, 8'h5A});
        xfer(1'b0, 1'b1, 20'h00010, 1'b0, '0, '0);
        bad(1'b1, 1'b0, 1'b1);
        bad(1'b0, 1'b1, 1'b1);
        rd_op();

        // Auto-increment with wrap at the top of the address space.
        sel = 1;
        astb_op(20'hFFFFF, 1'b0);
        wr_op(64'hAAAA_0000_1111_2222, 8'hA1);
        wr_op(64'hBBBB_3333_4444_5555, 8'hB2);
        astb_op(20'hFFFFF, 1'b0);
        rd_op();
        chk("t3_rd_a", {data_w[1], tag_w[1]}, {64'hAAAA_0000_1111_2222, 8'hA1});
        rd_op();
        chk("t3_rd_b", {data_w[1], tag_w[1]}, {64'hBBBB_3333_4444_5555, 8'hB2});
        astb_op(20'h00000, 1'b0);
        rd_op();
        chk("t3_wrap", {data_w[1], tag_w[1]}, {64'hBBBB_3333_4444_5555, 8'hB2});

        // Atomic read-modify-write with INC=1.
        astb_op(20'h00200, 1'b0);
        wr_op(64'h1111, 8'h11);
        wr_op(64'h2222, 8'h22);
        astb_op(20'h00200, 1'b1);
        rd_op();
        chk("t4_locked_rd", {data_w[1], tag_w[1]}, {64'h1111, 8'h11});
        chk("t4_still_locked", lck_w[1], 1);
        wr_op(64'h55, 8'h55);
        chk("t4_unlocked", lck_w[1], 0);
        rd_op();
        chk("t4_next_addr", {data_w[1], tag_w[1]}, {64'h2222, 8'h22});
        astb_op(20'h00200, 1'b0);
        rd_op();
        chk("t4_rmw_data", {data_w[1], tag_w[1]}, {64'h55, 8'h55});

        // Request while busy is rejected; the read in flight still completes.
        astb_op(20'h00200, 1'b0);
        rd = 1'b1;
        step(); clr();
        chk("t2_ready_n1", rdy_w[1], 0);
        step();
        ad = {44'h0, 20'h00777}; astb = 1'b1; rd = 1'b1;
        step(); clr();
        chk("t2_err", err_w[1], 1);
        chk("t2_ready_n3", rdy_w[1], 0);
        chk("t2_no_ack_n3", ack_w[1], 0);
        step();
        chk("t2_ack", ack_w[1], 1);
        chk("t2_err_clear", err_w[1], 0);
        chk("t2_data", {data_w[1], tag_w[1]}, {64'h55, 8'h55});
        m_last[1] = {64'h55, 8'h55};
        m_addr[1] = 20'h00201;
        rd_op();
        chk("t2_addr_kept", {data_w[1], tag_w[1]}, {64'h2222, 8'h22});
        bad(1'b1, 1'b0, 1'b1);
        bad(1'b0, 1'b1, 1'b1);

        // Reset in the middle of a WAIT=5 write abandons it.
        sel = 2;
        astb_op(20'h00400, 1'b0);
        wr_op(64'h0A0A_0B0B_0C0C_0D0D, 8'h0E);
        rd_op();
        astb_op(20'h00400, 1'b1);
        ad = 64'hFFFF_EEEE_DDDD_CCCC; tg = 8'hFF; wr = 1'b1;
        step(); clr();
        step();
        reset_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            chk("t6_rst_data", {data_w[s], tag_w[s]}, 0);
            chk("t6_rst_ack", ack_w[s], 0);
            chk("t6_rst_lock", lck_w[s], 0);
            chk("t6_rst_ready", rdy_w[s], 1);
        end
        sel = 2;
        model_reset();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_no_ack", ack_w[2], 0);
        end
        astb_op(20'h00400, 1'b0);
        rd_op();
        chk("t6_old_data", {data_w[2], tag_w[2]}, {64'h0A0A_0B0B_0C0C_0D0D, 8'h0E});

        // Randomized traffic on each instance inside a pre-written window.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int i = 0; i < 16; i++) begin
                astb_op(20'h00300 + 20'(i), 1'b0);
                wr_op({$urandom, $urandom}, 8'($urandom));
            end
            for (int n = 0; n < 60; n++) begin
                r = $urandom_range(0, 9);
                a = 20'h00300 + 20'($urandom_range(0, 15));
                if (r <= 1) begin
                    astb_op(a, ($urandom_range(0, 3) == 0));
                end else if (r <= 4) begin
                    wr_op({$urandom, $urandom}, 8'($urandom));
                end else if (r <= 7) begin
                    if (!m_mem.exists(key_of(s, m_addr[s]))) astb_op(a, 1'b0);
                    rd_op();
                end else if (r == 8) begin
                    xfer(1'b0, 1'b1, a, ($urandom_range(0, 3) == 0), '0, '0);
                end else begin
                    case ($urandom_range(0, 2))
                        0: bad(1'b1, 1'b0, 1'b1);
                        1: bad(1'b0, 1'b1, 1'b1);
                        default: bad(1'b1, 1'b1, 1'b1);
                    endcase
                end
            end
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
